// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int hold_w(input int hold);
    return $clog2(hold);
  endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Bundle between the sweep checker (master) and the bench or harness around the block under test (slave).
interface tt_sweep_checker_if #(
  parameter int N = 4
);
  logic         start;
  logic         f;
  logic [N-1:0] vec;
  logic         busy;
  logic         sample_stb;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic [N-1:0] first_err_vec;
  logic         first_err_valid;

  modport master (
    input  start, f,
    output vec, busy, sample_stb, done, pass, err_count, first_err_vec, first_err_valid
  );

  modport slave (
    output start, f,
    input  vec, busy, sample_stb, done, pass, err_count, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/tt_hold_timer.sv
// Counts the cycles a vector has been held; o_tc marks the last cycle of the hold window.
module tt_hold_timer
  import tt_sweep_pkg::*;
#(
  parameter int HOLD = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int W = hold_w(HOLD);
  localparam logic [W-1:0] LAST = W'(HOLD - 1);

  logic [W-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == LAST);

  // Wraps to zero on terminal count so the next vector gets a full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: walks all 2^N vectors, samples f at the end of each
// hold window and records mismatches against the golden table EXPECT.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int                 N      = 4,
  parameter int                 HOLD   = 20,
  parameter logic [(1<<N)-1:0]  EXPECT = 16'h6996
) (
  input logic               clk,
  input logic               rst,
  tt_sweep_checker_if.master bus
);

  localparam logic [N-1:0] VMAX = '1;

  state_t       r_state;
  logic [N-1:0] r_vec;
  logic         r_busy;
  logic         r_done;
  logic         r_pass;
  logic [N:0]   r_err;
  logic [N-1:0] r_fev;
  logic         r_fv;

  logic         w_run;
  logic         w_stb;
  logic         w_mis;
  logic [N:0]   w_err_nxt;

  assign w_run     = (r_state == RUN);
  assign w_mis     = (bus.f != EXPECT[r_vec]);
  assign w_err_nxt = r_err + (N+1)'(w_mis);

  tt_hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_run),
    .i_clr (!w_run),
    .o_tc  (w_stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fev   <= '0;
      r_fv    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state <= RUN;
            r_vec   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fev   <= '0;
            r_fv    <= 1'b0;
          end
        end
        RUN: begin
          // Start is deliberately ignored here; a sweep always runs to completion.
          if (w_stb) begin
            r_err <= w_err_nxt;
            if (w_mis && !r_fv) begin
              r_fev <= r_vec;
              r_fv  <= 1'b1;
            end
            if (r_vec == VMAX) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_nxt == '0);
            end else begin
              r_vec <= r_vec + N'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.vec             = r_vec;
  assign bus.busy            = r_busy;
  assign bus.sample_stb      = w_stb;
  assign bus.done            = r_done;
  assign bus.pass            = r_pass;
  assign bus.err_count       = r_err;
  assign bus.first_err_vec   = r_fev;
  assign bus.first_err_valid = r_fv;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: two instances (N=4/HOLD=20 parity, N=2/HOLD=2 AND table) checked
// every cycle against a timeline model, plus hand-computed end-of-sweep expectations.
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;

  int n_checks = 0;
  int n_errs   = 0;

  // Block-under-test behaviour selector: 0 parity, 1 parity with vec 5 inverted, 2 tied 0, 3 AND, 4 OR
  int mode [2] = '{0, 3};

  int          n_of  [2] = '{4, 2};
  int          h_of  [2] = '{20, 2};
  logic [15:0] exp_of[2] = '{16'h6996, 16'h0008};

  bit m_act [2];
  int m_t   [2];
  int m_mode[2];

  always #5 clk = ~clk;

  tt_sweep_checker_if #(.N(4)) bus_a();
  tt_sweep_checker_if #(.N(2)) bus_b();

  function automatic logic f_of(input int md, input int v);
    logic [7:0] vv;
    vv = v[7:0];
    case (md)
      0:       return ^vv[3:0];
      1:       return (^vv[3:0]) ^ (vv == 8'd5);
      2:       return 1'b0;
      3:       return &vv[1:0];
      4:       return |vv[1:0];
      default: return 1'b0;
    endcase
  endfunction

  assign bus_a.f = f_of(mode[0], int'(bus_a.vec));
  assign bus_b.f = f_of(mode[1], int'(bus_b.vec));

  tt_sweep_checker #(.N(4), .HOLD(20), .EXPECT(16'h6996)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  tt_sweep_checker #(.N(2), .HOLD(2), .EXPECT(4'b1000)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  function automatic bit mism(input int s, input int md, input int k);
    logic [15:0] e;
    e = exp_of[s];
    return f_of(md, k) != e[k];
  endfunction

  function automatic int cnt_err(input int s, input int md, input int ns);
    int c;
    c = 0;
    for (int k = 0; k < ns; k++) if (mism(s, md, k)) c++;
    return c;
  endfunction

  function automatic int first_err(input int s, input int md, input int ns);
    for (int k = 0; k < ns; k++) if (mism(s, md, k)) return k;
    return -1;
  endfunction

  // 0 vec, 1 busy, 2 done, 3 sample_stb, 4 pass, 5 err_count, 6 first_err_vec, 7 first_err_valid
  function automatic logic [31:0] get_sig(input int s, input int idx);
    if (s == 0) begin
      case (idx)
        0: return 32'(bus_a.vec);
        1: return 32'(bus_a.busy);
        2: return 32'(bus_a.done);
        3: return 32'(bus_a.sample_stb);
        4: return 32'(bus_a.pass);
        5: return 32'(bus_a.err_count);
        6: return 32'(bus_a.first_err_vec);
        default: return 32'(bus_a.first_err_valid);
      endcase
    end else begin
      case (idx)
        0: return 32'(bus_b.vec);
        1: return 32'(bus_b.busy);
        2: return 32'(bus_b.done);
        3: return 32'(bus_b.sample_stb);
        4: return 32'(bus_b.pass);
        5: return 32'(bus_b.err_count);
        6: return 32'(bus_b.first_err_vec);
        default: return 32'(bus_b.first_err_valid);
      endcase
    end
  endfunction

  function automatic logic get_start(input int s);
    return (s == 0) ? bus_a.start : bus_b.start;
  endfunction

  task automatic set_start(input int s, input logic v);
    if (s == 0) bus_a.start = v;
    else        bus_b.start = v;
  endtask

  task automatic chk(input int s, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL inst%0d %s: got %0d expected %0d at %0t", s, name, act, exp, $time);
    end
  endtask

  string sig_name [8] = '{"vec", "busy", "done", "sample_stb", "pass", "err_count",
                          "first_err_vec", "first_err_valid"};

  task automatic chk_zero(input string tag);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) chk(s, {tag, ".", sig_name[i]}, get_sig(s, i), 32'd0);
  endtask

  // Timeline model: cycles elapsed since the accepted start edge, per instance.
  always @(posedge clk or posedge rst) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        m_act[s] <= 1'b0;
        m_t[s]   <= 0;
      end else if ((!m_act[s] || m_t[s] >= (h_of[s] << n_of[s])) && get_start(s)) begin
        m_act[s]  <= 1'b1;
        m_t[s]    <= 0;
        m_mode[s] <= mode[s];
      end else if (m_act[s] && m_t[s] < (h_of[s] << n_of[s])) begin
        m_t[s] <= m_t[s] + 1;
      end
    end
  end

  always @(negedge clk) begin
    int e [8];
    int sz, tt, ns, fe;
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < 8; i++) e[i] = 0;
        if (m_act[s]) begin
          sz = 1 << n_of[s];
          tt = sz * h_of[s];
          if (m_t[s] < tt) begin
            e[0] = m_t[s] / h_of[s];
            e[1] = 1;
            e[3] = (m_t[s] % h_of[s] == h_of[s] - 1) ? 1 : 0;
            ns   = m_t[s] / h_of[s];
          end else begin
            e[0] = sz - 1;
            e[2] = 1;
            ns   = sz;
          end
          e[5] = cnt_err(s, m_mode[s], ns);
          if (m_t[s] >= tt) e[4] = (e[5] == 0) ? 1 : 0;
          fe = first_err(s, m_mode[s], ns);
          e[6] = (fe >= 0) ? fe : 0;
          e[7] = (fe >= 0) ? 1 : 0;
        end
        for (int i = 0; i < 8; i++) chk(s, sig_name[i], get_sig(s, i), 32'(e[i]));
      end
    end
  end

  // Starts a sweep on instance s with behaviour md; optionally re-pulses start at cycle
  // restart_at, or stops waiting at cycle stop_at. Counts cycles from start edge and stb pulses.
  task automatic run_sweep(input int s, input int md, input int restart_at, input int stop_at,
                           output int cyc, output int pulses);
    @(negedge clk);
    mode[s] = md;
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    cyc    = 0;
    pulses = 0;
    while (get_sig(s, 2) == 0 && cyc < 2000 && cyc != stop_at) begin
      if (get_sig(s, 3) == 1) pulses++;
      set_start(s, (cyc == restart_at) ? 1'b1 : 1'b0);
      @(negedge clk);
      cyc++;
    end
    set_start(s, 1'b0);
    if (stop_at < 0) chk(s, "done_within_budget", get_sig(s, 2), 32'd1);
  endtask

  initial begin
    int cyc, pul;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    chk_zero("in_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_zero("after_reset");

    chk(0, "model_parity_errs", cnt_err(0, 0, 16), 0);
    chk(0, "model_flip5_errs", cnt_err(0, 1, 16), 1);
    chk(0, "model_flip5_first", first_err(0, 1, 16), 5);
    chk(0, "model_tie0_errs", cnt_err(0, 2, 16), 8);
    chk(1, "model_or_errs", cnt_err(1, 4, 4), 2);

    // Clean parity sweep, with a start pulse at cycle 50 that must be ignored
    run_sweep(0, 0, 50, -1, cyc, pul);
    chk(0, "parity.cycles", cyc, 320);
    chk(0, "parity.stb_pulses", pul, 16);
    chk(0, "parity.pass", get_sig(0, 4), 1);
    chk(0, "parity.err_count", get_sig(0, 5), 0);
    chk(0, "parity.first_err_valid", get_sig(0, 7), 0);

    // Started from DONE: counts must be cleared
    run_sweep(0, 1, -1, -1, cyc, pul);
    chk(0, "flip5.cycles", cyc, 320);
    chk(0, "flip5.err_count", get_sig(0, 5), 1);
    chk(0, "flip5.first_err_vec", get_sig(0, 6), 5);
    chk(0, "flip5.first_err_valid", get_sig(0, 7), 1);
    chk(0, "flip5.pass", get_sig(0, 4), 0);

    run_sweep(0, 2, -1, -1, cyc, pul);
    chk(0, "tie0.err_count", get_sig(0, 5), 8);
    chk(0, "tie0.first_err_vec", get_sig(0, 6), 1);
    chk(0, "tie0.pass", get_sig(0, 4), 0);
    chk(0, "tie0.done", get_sig(0, 2), 1);

    // Asynchronous reset mid-sweep, between clock edges
    run_sweep(0, 2, -1, 100, cyc, pul);
    chk(0, "midsweep.cycles", cyc, 100);
    chk(0, "midsweep.err_count", get_sig(0, 5), 3);
    chk(0, "midsweep.busy", get_sig(0, 1), 1);
    #3 rst = 1'b1;
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;

    run_sweep(0, 0, -1, -1, cyc, pul);
    chk(0, "restart.cycles", cyc, 320);
    chk(0, "restart.pass", get_sig(0, 4), 1);
    chk(0, "restart.err_count", get_sig(0, 5), 0);
    chk(0, "restart.first_err_valid", get_sig(0, 7), 0);

    // Small instance: N=2, HOLD=2, table = AND
    run_sweep(1, 3, -1, -1, cyc, pul);
    chk(1, "and.cycles", cyc, 8);
    chk(1, "and.stb_pulses", pul, 4);
    chk(1, "and.pass", get_sig(1, 4), 1);
    chk(1, "and.err_count", get_sig(1, 5), 0);

    run_sweep(1, 4, -1, -1, cyc, pul);
    chk(1, "or.cycles", cyc, 8);
    chk(1, "or.err_count", get_sig(1, 5), 2);
    chk(1, "or.first_err_vec", get_sig(1, 6), 1);
    chk(1, "or.pass", get_sig(1, 4), 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have ended", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
